// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Execute stage fed by the register file. Takes operands A/B, an
//            opcode and a destination address, computes the result and drives
//            the register-file write port (W/Wen/WA) plus Z/C/N flags.
//            Single-cycle ops complete on the accept edge. MUL runs as an
//            iterative shift-add sequence and holds ready low until it is done.
// Ports    : clk, rst_n          clock / async active-low reset
//            start, ready        issue handshake (accept on start && ready)
//            op, A, B, dest      operation, operands, destination register
//            W, Wen, WA          write-back data, enable pulse, address
//            flag_z/c/n          zero, carry/borrow, negative
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int MUL_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [ADDR_W-1:0] dest,
    output logic [DATA_W-1:0] W,
    output logic              Wen,
    output logic [ADDR_W-1:0] WA,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_n
);

    localparam int c_cnt_w = $clog2(MUL_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MUL_CYCLES - 1);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_mul  = 1'b1;

    localparam logic [3:0] c_op_add   = 4'd0;
    localparam logic [3:0] c_op_sub   = 4'd1;
    localparam logic [3:0] c_op_and   = 4'd2;
    localparam logic [3:0] c_op_or    = 4'd3;
    localparam logic [3:0] c_op_xor   = 4'd4;
    localparam logic [3:0] c_op_not   = 4'd5;
    localparam logic [3:0] c_op_shl   = 4'd6;
    localparam logic [3:0] c_op_shr   = 4'd7;
    localparam logic [3:0] c_op_mul   = 4'd8;
    localparam logic [3:0] c_op_passb = 4'd9;

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;

    logic [DATA_W-1:0]   r_w;
    logic [ADDR_W-1:0]   r_wa;
    logic                r_wen;
    logic                r_z;
    logic                r_c;
    logic                r_n;

    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_acc;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_dest;

    logic                w_accept;
    logic                w_mul_last;
    logic [2*DATA_W-1:0] w_acc_next;
    logic [DATA_W:0]     w_ext;
    logic [DATA_W-1:0]   w_res;
    logic                w_c;
    logic                w_write;
    logic                w_is_mul;

    assign ready      = (r_state == c_st_idle);
    assign w_accept   = start && ready;
    assign w_mul_last = (r_state == c_st_mul) && (r_cnt == c_cnt_last);

    // Multiplier and multiplicand are shifted each step, so bit 0 of the
    // multiplier always selects whether the current partial product is added.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle result and carry; w_ext carries the extra MSB that holds
    // carry-out for ADD and borrow for SUB (9-bit wrap sets it iff A < B).
    always_comb begin
        w_ext    = '0;
        w_res    = '0;
        w_c      = 1'b0;
        w_write  = 1'b1;
        w_is_mul = 1'b0;
        case (op)
            c_op_add: begin
                w_ext = {1'b0, A} + {1'b0, B};
                w_res = w_ext[DATA_W-1:0];
                w_c   = w_ext[DATA_W];
            end
            c_op_sub: begin
                w_ext = {1'b0, A} - {1'b0, B};
                w_res = w_ext[DATA_W-1:0];
                w_c   = w_ext[DATA_W];
            end
            c_op_and:   w_res = A & B;
            c_op_or:    w_res = A | B;
            c_op_xor:   w_res = A ^ B;
            c_op_not:   w_res = ~A;
            c_op_shl: begin
                w_res = {A[DATA_W-2:0], 1'b0};
                w_c   = A[DATA_W-1];
            end
            c_op_shr: begin
                w_res = {1'b0, A[DATA_W-1:1]};
                w_c   = A[0];
            end
            c_op_mul: begin
                w_write  = 1'b0;
                w_is_mul = 1'b1;
            end
            c_op_passb: w_res = B;
            default:    w_write = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept && w_is_mul) w_state_next = c_st_mul;
            c_st_mul:  if (w_mul_last)           w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w      <= '0;
            r_wa     <= '0;
            r_wen    <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_dest   <= '0;
        end else if (r_state == c_st_mul) begin
            r_wen    <= 1'b0;
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_w   <= w_acc_next[DATA_W-1:0];
                r_wa  <= r_dest;
                r_wen <= 1'b1;
                r_z   <= (w_acc_next[DATA_W-1:0] == '0);
                r_n   <= w_acc_next[DATA_W-1];
                r_c   <= |w_acc_next[2*DATA_W-1:DATA_W];
            end
        end else begin
            // Default to no write; W/WA/flags hold unless a writing op lands.
            r_wen <= 1'b0;
            if (w_accept) begin
                if (w_is_mul) begin
                    r_mcand  <= {{DATA_W{1'b0}}, A};
                    r_mplier <= B;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_dest   <= dest;
                end else if (w_write) begin
                    r_w   <= w_res;
                    r_wa  <= dest;
                    r_wen <= 1'b1;
                    r_z   <= (w_res == '0);
                    r_n   <= w_res[DATA_W-1];
                    r_c   <= w_c;
                end
            end
        end
    end

    assign W      = r_w;
    assign WA     = r_wa;
    assign Wen    = r_wen;
    assign flag_z = r_z;
    assign flag_c = r_c;
    assign flag_n = r_n;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Scoreboard bench for alu_exec_stage. The driver pushes the
//            expected write-back (with its due cycle) for every accepted op;
//            a forked monitor pops and compares on every Wen pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 4;
    localparam int MUL_CYCLES = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              ready;
    logic [3:0]        op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] W;
    logic              Wen;
    logic [ADDR_W-1:0] WA;
    logic              flag_z;
    logic              flag_c;
    logic              flag_n;

    alu_exec_stage #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ready  (ready),
        .op     (op),
        .A      (A),
        .B      (B),
        .dest   (dest),
        .W      (W),
        .Wen    (Wen),
        .WA     (WA),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_n (flag_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] w;
        logic [3:0] wa;
        logic       z;
        logic       c;
        logic       n;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    exp_t last_exp;

    // Reference: results derived from plain integer arithmetic.
    function automatic exp_t model(input int o, input int a, input int b, input int d);
        exp_t r;
        int   x;
        r.wa = 4'(d);
        r.c  = 1'b0;
        x    = 0;
        case (o)
            0: begin x = a + b;            r.c = (x > 255); end
            1: begin x = a - b + 256;      r.c = (a < b);   end
            2: x = a & b;
            3: x = a | b;
            4: x = a ^ b;
            5: x = 255 - a;
            6: begin x = a * 2;            r.c = (a >= 128); end
            7: begin x = a / 2;            r.c = (a % 2 == 1); end
            8: begin x = a * b;            r.c = (x >= 256); end
            9: x = b;
            default: x = 0;
        endcase
        r.w   = 8'(x % 256);
        r.z   = ((x % 256) == 0);
        r.n   = ((x % 256) >= 128);
        r.due = 0;
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && Wen) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_wen got W=0x%0h WA=%0d at cycle %0d, want no write",
                             W, WA, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (cyc != e.due || W != e.w || WA != e.wa ||
                        flag_z != e.z || flag_c != e.c || flag_n != e.n) begin
                        errors++;
                        $display("FAIL writeback got cyc=%0d W=0x%0h WA=%0d zcn=%b%b%b want cyc=%0d W=0x%0h WA=%0d zcn=%b%b%b",
                                 cyc, W, WA, flag_z, flag_c, flag_n,
                                 e.due, e.w, e.wa, e.z, e.c, e.n);
                    end
                end
            end else if (rst_n && sbq.size() != 0 && cyc > sbq[0].due) begin
                checks++;
                errors++;
                $display("FAIL missed_wen got no write by cycle %0d want W=0x%0h WA=%0d at cycle %0d",
                         cyc, sbq[0].w, sbq[0].wa, sbq[0].due);
                void'(sbq.pop_front());
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    // While the stage is busy it keeps start high with junk ops that must
    // be ignored.
    task automatic issue(input int o, input int a, input int b, input int d);
        exp_t e;
        int   guard;
        guard = 0;
        while (!ready && guard < 40) begin
            start = 1'b1;
            op    = 4'($urandom);
            A     = 8'($urandom);
            B     = 8'($urandom);
            dest  = 4'($urandom);
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            chk("ready_timeout", 0, 1);
        end else begin
            start = 1'b1;
            op    = 4'(o);
            A     = 8'(a);
            B     = 8'(b);
            dest  = 4'(d);
            if (o <= 9) begin
                e     = model(o, a, b, d);
                e.due = cyc + 1 + ((o == 8) ? MUL_CYCLES : 0);
                sbq.push_back(e);
                last_exp = e;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sbq.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        int cnt;
        int o;
        last_exp = model(15, 0, 0, 0);
        last_exp.z = 1'b0;
        rst_n = 1'b0;
        start = 1'b1;
        op    = 4'd0;
        A     = 8'h11;
        B     = 8'h22;
        dest  = 4'd1;
        fork
            monitor_loop();
        join_none

        // Reset held with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wen", Wen, 0);
            chk("rst_w", W, 0);
            chk("rst_ready", ready, 1);
            chk("rst_flags", {flag_z, flag_c, flag_n}, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_w", W, 0);

        // ADD overflow.
        issue(0, 8'hF0, 8'h20, 3);
        chk("add_w", W, 8'h10);
        chk("add_wa", WA, 3);
        chk("add_wen", Wen, 1);
        chk("add_zcn", {flag_z, flag_c, flag_n}, 3'b010);
        @(negedge clk);
        chk("add_wen_drop", Wen, 0);

        // SUB zero, then borrow, back to back.
        issue(1, 8'h05, 8'h05, 4);
        chk("sub0_w", W, 8'h00);
        chk("sub0_zc", {flag_z, flag_c}, 2'b10);
        issue(1, 8'h03, 8'h05, 5);
        chk("sub1_w", W, 8'hFE);
        chk("sub1_cn", {flag_c, flag_n}, 2'b11);
        drain();

        // MUL with ready-low duration.
        issue(8, 8'h0D, 8'h0B, 7);
        cnt = 0;
        while (!ready && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", cnt, MUL_CYCLES);
        chk("mul_w", W, 8'h8F);
        chk("mul_wa", WA, 7);
        chk("mul_wen", Wen, 1);
        chk("mul_c", flag_c, 0);
        @(negedge clk);
        chk("mul_wen_drop", Wen, 0);

        // MUL with upper-byte carry, then a stalled ADD issued with junk ops.
        issue(8, 8'h20, 8'h10, 2);
        issue(0, 8'h01, 8'h02, 9);
        drain();

        // NOP holds W/WA/flags.
        issue(12, 8'hFF, 8'hFF, 15);
        chk("nop_wen", Wen, 0);
        chk("nop_w", W, last_exp.w);
        chk("nop_wa", WA, last_exp.wa);
        chk("nop_flags", {flag_z, flag_c, flag_n}, {last_exp.z, last_exp.c, last_exp.n});

        // Reset in the 4th MUL cycle aborts it.
        issue(8, 8'hFF, 8'hFF, 6);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("abort_wen", Wen, 0);
        chk("abort_w", W, 0);
        chk("abort_ready", ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_w_after", W, 0);
        chk("abort_ready_after", ready, 1);

        // Random traffic, with MUL biased in and occasional idle gaps.
        for (int i = 0; i < 300; i++) begin
            o = ($urandom_range(0, 4) == 0) ? 8 : int'($urandom_range(0, 15));
            issue(o, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                op = 4'($urandom);
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
